fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage feeding the IF/ID pipeline_register. Holds the PC and issues one
//  request at a time to a variable-latency instruction memory (req/ready handshake). Presents
//  {opcode, 64-bit payload} to IF/ID and drives its flush on a taken branch. Supports stall
//  hold, branch redirect including dropping in-flight responses, and HALT.
// PARAMETERS
//  RESET_PC     16'h0000  PC value loaded on reset
//  HALT_OPCODE  4'hF      opcode that stops fetch once delivered
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  stall_in       in   1   hazard-unit stall; also wired directly to the IF/ID stall input
//  branch_taken   in   1   redirect pulse from EX
//  branch_target  in   16  redirect PC, valid while branch_taken=1
//  mem_ready      in   1   memory response strobe; mem_data is valid in the same cycle
//  mem_data       in   16  instruction word
//  mem_req        out  1   registered; request outstanding
//  mem_addr       out  16  registered; request address
//  opcode_out     out  4   instr[15:12] when fetch_valid=1, else 0; goes to IF/ID opcode_in
//  fetch_data     out  64  {16'h0, pc, pc+2, instr} when fetch_valid=1, else 64'h0
//  fetch_valid    out  1   registered; payload holds a real instruction
//  if_id_flush    out  1   combinational = branch_taken
//  halted         out  1   1 while in HALT
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=0, fetch_valid=0, halted=0.
//   The held instruction register resets to 0; all outputs read 0. Any outstanding memory
//   transaction is abandoned; the memory shares rst.
//  States: IDLE, REQ, DROP, HOLD, HALT. Only one request is ever outstanding.
//  IDLE: next edge -> REQ, mem_req<=1, mem_addr<=pc.
//  REQ: mem_req=1 is held until mem_ready is sampled high. On each edge:
//   - branch_taken & mem_ready: discard data, pc<=target, mem_addr<=target, fetch_valid<=0.
//     Stay in REQ; mem_req stays 1.
//   - branch_taken & !mem_ready: pc<=target, fetch_valid<=0 -> DROP.
//   - mem_ready & !stall_in: instr<=mem_data, fetch_valid<=1, pc<=pc+2, mem_addr<=pc+2.
//     If mem_data[15:12]==HALT_OPCODE: -> HALT, mem_req<=0. Otherwise stay in REQ.
//   - mem_ready & stall_in: instr<=mem_data, fetch_valid<=1, mem_req<=0 -> HOLD.
//   - no mem_ready, no branch: fetch_valid<=0 (bubble).
//   - stall_in=1 while fetch_valid=1: payload held unchanged.
//  DROP: mem_req stays 1, mem_addr unchanged. On mem_ready: discard data,
//   mem_addr<=pc -> REQ. A further branch_taken in DROP only updates pc.
//  HOLD: payload held while stall_in=1. On the first edge with stall_in=0, IF/ID consumes it;
//   then pc<=pc+2, mem_addr<=pc+2, mem_req<=1, fetch_valid<=0 -> REQ.
//   branch_taken in HOLD takes priority: fetch_valid<=0, pc/mem_addr<=target -> REQ.
//  HALT: halted=1, mem_req=0, pc frozen, fetch_valid<=0 once IF/ID has consumed the HALT word.
//   branch_taken (an older branch resolving) -> REQ at target, halted<=0.
//  Branch has priority over stall and over memory response in every state.
//  Latency: an instruction appears on fetch_data the cycle after its mem_ready edge.
//   With 1-cycle memory, throughput is 1 instruction/cycle.
//  PC arithmetic is 16-bit modulo: 16'hFFFE + 2 = 16'h0000. pc[0] is never set by +2.
//  Bubbles (fetch_valid=0) present all-zero opcode and payload. IF/ID captures these as NOP.
// TESTING
//  1. Reset, 1-cycle memory, no stalls -> mem_addr 0,2,4,... on consecutive cycles;
//     fetch_data[15:0] tracks mem_data, [31:16]=pc+2.
//  2. 3-cycle memory -> mem_req high 3 cycles per word; fetch_valid=0 bubbles between
//     instructions; mem_addr stable while waiting.
//  3. stall_in high 4 cycles when word 16'h1234 arrives at pc=6 -> HOLD; payload frozen;
//     next request is to addr 8 after stall drops.
//  4. branch_taken, target 16'h0040, while a 3-cycle request is pending -> DROP; if_id_flush=1
//     that cycle; the stale response is discarded; next mem_addr=0x0040.
//  5. Word 16'hF000 at pc=0x10 -> halted=1 and mem_req=0 after delivery; a later
//     branch_taken to 0x20 resumes fetch at 0x20.
//  6. pc=16'hFFFE -> next mem_addr=16'h0000. Assert rst mid-REQ -> all outputs 0 immediately;
//     fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to a variable-latency
// instruction memory and presents {opcode, payload} to the IF/ID register.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        mem_ready,
    input  logic [15:0] mem_data,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [3:0]  opcode_out,
    output logic [63:0] fetch_data,
    output logic        fetch_valid,
    output logic        if_id_flush,
    output logic        halted
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] DROP = 3'd2;
    localparam logic [2:0] HOLD = 3'd3;
    localparam logic [2:0] HALT = 3'd4;

    logic [2:0]  state;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] pc_inc;
    logic [15:0] instr_pc_inc;
    logic        resp_is_halt;
    logic        held_is_halt;

    assign pc_inc       = pc + 16'd2;
    assign instr_pc_inc = instr_pc + 16'd2;
    assign resp_is_halt = (mem_data[15:12] == HALT_OPCODE);
    assign held_is_halt = (instr[15:12] == HALT_OPCODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            mem_req     <= 1'b0;
            mem_addr    <= 16'h0000;
            fetch_valid <= 1'b0;
            instr       <= 16'h0000;
            instr_pc    <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    mem_req  <= 1'b1;
                    if (branch_taken) begin
                        pc       <= branch_target;
                        mem_addr <= branch_target;
                    end else begin
                        mem_addr <= pc;
                    end
                end
                REQ: begin
                    if (branch_taken) begin
                        pc          <= branch_target;
                        fetch_valid <= 1'b0;
                        // A response arriving with the branch is stale; re-issue at target now.
                        if (mem_ready) mem_addr <= branch_target;
                        else           state    <= DROP;
                    end else if (mem_ready) begin
                        instr       <= mem_data;
                        instr_pc    <= pc;
                        fetch_valid <= 1'b1;
                        if (stall_in) begin
                            mem_req <= 1'b0;
                            state   <= HOLD;
                        end else begin
                            pc       <= pc_inc;
                            mem_addr <= pc_inc;
                            if (resp_is_halt) begin
                                mem_req <= 1'b0;
                                state   <= HALT;
                            end
                        end
                    end else if (!(stall_in && fetch_valid)) begin
                        fetch_valid <= 1'b0;
                    end
                end
                DROP: begin
                    if (branch_taken) pc <= branch_target;
                    if (mem_ready) begin
                        mem_addr <= branch_taken ? branch_target : pc;
                        state    <= REQ;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        fetch_valid <= 1'b0;
                        pc          <= branch_target;
                        mem_addr    <= branch_target;
                        mem_req     <= 1'b1;
                        state       <= REQ;
                    end else if (!stall_in) begin
                        fetch_valid <= 1'b0;
                        // A HALT word parked by a stall still stops fetch once consumed.
                        if (held_is_halt) begin
                            state <= HALT;
                        end else begin
                            pc       <= pc_inc;
                            mem_addr <= pc_inc;
                            mem_req  <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end
                HALT: begin
                    if (branch_taken) begin
                        fetch_valid <= 1'b0;
                        pc          <= branch_target;
                        mem_addr    <= branch_target;
                        mem_req     <= 1'b1;
                        state       <= REQ;
                    end else if (!stall_in) begin
                        fetch_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem_req     <= 1'b0;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign opcode_out  = fetch_valid ? instr[15:12] : 4'h0;
    assign fetch_data  = fetch_valid ? {16'h0000, instr_pc, instr_pc_inc, instr} : 64'h0;
    assign if_id_flush = branch_taken;
    assign halted      = (state == HALT);

endmodule
